uart_mmio_host: RTL and testbench

UART_MMIO_HOST -- requirements
Module: uart_mmio_host

---
 rtl/uart_mmio_host_if.sv | 24 ++
 rtl/uart_mmio_host.sv | 99 +++++++++
 tb/tb_uart_mmio_host.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_host_if.sv
// Byte-stream handshakes (TX in, RX out) and the peripheral MMIO bus of uart_mmio_host.
// The master modport is the host's view; the slave modport is the surrounding system's view.
interface uart_mmio_host_if;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_ready;
   logic [1:0] mmio_addr;
   logic       mmio_wr_en;
   logic [7:0] mmio_wr_data;
   logic [7:0] mmio_rd_data;

   modport master (
      input  tx_byte, tx_valid, rx_ready, mmio_rd_data,
      output tx_ready, rx_byte, rx_valid, mmio_addr, mmio_wr_en, mmio_wr_data
   );

   modport slave (
      output tx_byte, tx_valid, rx_ready, mmio_rd_data,
      input  tx_ready, rx_byte, rx_valid, mmio_addr, mmio_wr_en, mmio_wr_data
   );
endinterface

// File: rtl/uart_mmio_host.sv
// Polling host for a UART-style MMIO peripheral: one-byte TX holding register and a
// one-byte RX output register with backpressure, driven by a POLL/READ_RX/WRITE_TX/HOLD FSM.
module uart_mmio_host #(
   parameter int unsigned TX_HOLDOFF = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_mmio_host_if.master    bus,
   output logic                busy,
   output logic [15:0]         tx_count,
   output logic [15:0]         rx_count
);
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_TX     = 2'b10;
   localparam logic [1:0] ADDR_RX     = 2'b11;
   localparam logic [3:0] HOLD_LOAD   = 4'(TX_HOLDOFF);

   typedef enum logic [1:0] {POLL, READ_RX, WRITE_TX, HOLD} state_t;

   state_t     state;
   logic       hold_full;
   logic [7:0] hold_data;
   logic [3:0] hold_cnt;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [1:0] mmio_addr;
   logic       mmio_wr_en;
   logic [7:0] mmio_wr_data;

   assign bus.tx_ready     = ~hold_full;
   assign bus.rx_byte      = rx_byte;
   assign bus.rx_valid     = rx_valid;
   assign bus.mmio_addr    = mmio_addr;
   assign bus.mmio_wr_en   = mmio_wr_en;
   assign bus.mmio_wr_data = mmio_wr_data;
   assign busy             = (state != POLL) || hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= POLL;
         hold_full    <= 1'b0;
         hold_data    <= '0;
         hold_cnt     <= '0;
         rx_byte      <= '0;
         rx_valid     <= 1'b0;
         mmio_addr    <= ADDR_STATUS;
         mmio_wr_en   <= 1'b0;
         mmio_wr_data <= '0;
         tx_count     <= '0;
         rx_count     <= '0;
      end else begin
         // Acceptance and consumption never collide with the FSM's own updates:
         // WRITE_TX only runs while full (tx_ready=0), READ_RX only while rx_valid=0.
         if (bus.tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= bus.tx_byte;
         end
         if (rx_valid && bus.rx_ready)
            rx_valid <= 1'b0;

         unique case (state)
            POLL: begin
               if (bus.mmio_rd_data[0] && !rx_valid) begin
                  state     <= READ_RX;
                  mmio_addr <= ADDR_RX;
               end else if (bus.mmio_rd_data[1] && hold_full) begin
                  state        <= WRITE_TX;
                  mmio_addr    <= ADDR_TX;
                  mmio_wr_en   <= 1'b1;
                  mmio_wr_data <= hold_data;
               end
            end
            READ_RX: begin
               rx_byte   <= bus.mmio_rd_data;
               rx_valid  <= 1'b1;
               rx_count  <= rx_count + 16'd1;
               state     <= POLL;
               mmio_addr <= ADDR_STATUS;
            end
            WRITE_TX: begin
               hold_full    <= 1'b0;
               tx_count     <= tx_count + 16'd1;
               hold_cnt     <= HOLD_LOAD;
               state        <= HOLD;
               mmio_addr    <= ADDR_STATUS;
               mmio_wr_en   <= 1'b0;
               mmio_wr_data <= '0;
            end
            HOLD: begin
               // Status read during the holdoff may still show the pre-write TX-ready bit.
               hold_cnt <= hold_cnt - 4'd1;
               if (hold_cnt == 4'd1)
                  state <= POLL;
            end
            default: state <= POLL;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mmio_host.sv
// Directed self-checking bench for uart_mmio_host with a combinational peripheral register model.
module tb_uart_mmio_host;
   logic        clk;
   logic        rst_n;
   logic        busy;
   logic [15:0] tx_count;
   logic [15:0] rx_count;
   logic [7:0]  status;
   logic [7:0]  rx_data;
   int          n_assert;
   int          n_fail;
   int          hits;

   uart_mmio_host_if bus ();

   uart_mmio_host #(.TX_HOLDOFF(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .tx_count (tx_count),
      .rx_count (rx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral: status at 01, RX data at 11, zero elsewhere.
   always_comb begin
      bus.mmio_rd_data = 8'h00;
      if (bus.mmio_addr == 2'b01) bus.mmio_rd_data = status;
      else if (bus.mmio_addr == 2'b11) bus.mmio_rd_data = rx_data;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      bus.tx_byte  = b;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'h00;
      bus.rx_ready = 1'b0;
      status   = 8'h00;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);

      chk("rst_tx_ready", 16'(bus.tx_ready), 16'h1);
      chk("rst_rx_valid", 16'(bus.rx_valid), 16'h0);
      chk("rst_rx_byte", 16'(bus.rx_byte), 16'h00);
      chk("rst_addr", 16'(bus.mmio_addr), 16'h1);
      chk("rst_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      chk("rst_wr_data", 16'(bus.mmio_wr_data), 16'h00);
      chk("rst_tx_count", tx_count, 16'h0);
      chk("rst_rx_count", rx_count, 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      rst_n = 1'b1;

      // Single TX followed by a back-to-back push during HOLD
      status = 8'h02;
      push(8'h41);
      chk("tx1_tx_ready", 16'(bus.tx_ready), 16'h0);
      chk("tx1_busy", 16'(busy), 16'h1);
      chk("tx1_poll_addr", 16'(bus.mmio_addr), 16'h1);
      step();
      chk("tx1_addr", 16'(bus.mmio_addr), 16'h2);
      chk("tx1_wr_en", 16'(bus.mmio_wr_en), 16'h1);
      chk("tx1_wr_data", 16'(bus.mmio_wr_data), 16'h41);
      step();
      chk("tx1_hold_addr", 16'(bus.mmio_addr), 16'h1);
      chk("tx1_hold_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      chk("tx1_count", tx_count, 16'h1);
      chk("tx1_ready_again", 16'(bus.tx_ready), 16'h1);
      push(8'h42);
      chk("tx2_hold2_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      step();
      chk("tx2_poll_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      chk("tx2_poll_addr", 16'(bus.mmio_addr), 16'h1);
      step();
      chk("tx2_wr_en", 16'(bus.mmio_wr_en), 16'h1);
      chk("tx2_wr_data", 16'(bus.mmio_wr_data), 16'h42);
      step(); step(); step();
      chk("tx2_idle_busy", 16'(busy), 16'h0);
      chk("tx2_count", tx_count, 16'h2);
      status = 8'h00;

      // Single RX with backpressure
      status  = 8'h01;
      rx_data = 8'h5A;
      step();
      chk("rx1_addr", 16'(bus.mmio_addr), 16'h3);
      chk("rx1_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      chk("rx1_busy", 16'(busy), 16'h1);
      step();
      chk("rx1_byte", 16'(bus.rx_byte), 16'h5A);
      chk("rx1_valid", 16'(bus.rx_valid), 16'h1);
      chk("rx1_count", rx_count, 16'h1);
      chk("rx1_addr_back", 16'(bus.mmio_addr), 16'h1);
      hits = 0;
      repeat (6) begin
         step();
         if (bus.mmio_addr == 2'b11) hits++;
      end
      chk("rx1_no_reread", 16'(hits), 16'h0);
      chk("rx1_valid_held", 16'(bus.rx_valid), 16'h1);
      chk("rx1_byte_held", 16'(bus.rx_byte), 16'h5A);
      bus.rx_ready = 1'b1;
      step();
      bus.rx_ready = 1'b0;
      status = 8'h00;
      chk("rx1_consumed", 16'(bus.rx_valid), 16'h0);

      // Collision: RX wins, TX on the next POLL decision
      push(8'h33);
      status  = 8'h03;
      rx_data = 8'hC3;
      step();
      chk("col_rx_addr", 16'(bus.mmio_addr), 16'h3);
      chk("col_rx_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      step();
      chk("col_rx_byte", 16'(bus.rx_byte), 16'hC3);
      chk("col_rx_count", rx_count, 16'h2);
      chk("col_poll_addr", 16'(bus.mmio_addr), 16'h1);
      step();
      chk("col_tx_addr", 16'(bus.mmio_addr), 16'h2);
      chk("col_tx_wr_en", 16'(bus.mmio_wr_en), 16'h1);
      chk("col_tx_data", 16'(bus.mmio_wr_data), 16'h33);
      bus.rx_ready = 1'b1;
      status = 8'h00;
      step();
      bus.rx_ready = 1'b0;
      chk("col_rx_consumed", 16'(bus.rx_valid), 16'h0);
      chk("col_tx_count", tx_count, 16'h3);
      step(); step();

      // Busy peripheral: pending byte must wait
      push(8'h77);
      hits = 0;
      repeat (100) begin
         step();
         if (bus.mmio_wr_en) hits++;
      end
      chk("bsy_no_write", 16'(hits), 16'h0);
      chk("bsy_tx_ready", 16'(bus.tx_ready), 16'h0);
      chk("bsy_busy", 16'(busy), 16'h1);
      status = 8'h02;
      step();
      chk("bsy_wr_en", 16'(bus.mmio_wr_en), 16'h1);
      chk("bsy_wr_data", 16'(bus.mmio_wr_data), 16'h77);
      step();
      chk("bsy_tx_count", tx_count, 16'h4);

      // Reset in HOLD with a byte pending
      push(8'h99);
      chk("rsth_pending", 16'(bus.tx_ready), 16'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("rsth_addr", 16'(bus.mmio_addr), 16'h1);
      chk("rsth_wr_en", 16'(bus.mmio_wr_en), 16'h0);
      chk("rsth_tx_ready", 16'(bus.tx_ready), 16'h1);
      chk("rsth_tx_count", tx_count, 16'h0);
      chk("rsth_rx_count", rx_count, 16'h0);
      chk("rsth_busy", 16'(busy), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      repeat (10) begin
         step();
         if (bus.mmio_wr_en) hits++;
      end
      chk("rsth_no_write", 16'(hits), 16'h0);
      chk("rsth_count_after", tx_count, 16'h0);

      // Counter wrap from a preset value
      force dut.tx_count = 16'hFFFE;
      step();
      release dut.tx_count;
      push(8'hAA);
      step(); step();
      chk("wrap_ffff", tx_count, 16'hFFFF);
      step(); step();
      push(8'hBB);
      step(); step();
      chk("wrap_zero", tx_count, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
